eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer_if.sv | 26 ++
 rtl/eth_tx_framer.sv | 166 ++++++++++++++++
 tb/tb_eth_tx_framer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_framer_if.sv
// Framer-side bus: upstream FIFO read port, frame-ready strobe, MAC byte stream and status.
// master = framer, slave = FIFO/MAC environment.
interface eth_tx_framer_if;
  logic       frame_ready;
  logic [8:0] frame_len;
  logic       fifo_empty;
  logic [7:0] read_data;
  logic       read_enable;
  logic       read_start;
  logic       read_error;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_err;
  logic       busy;

  modport master (
    input  frame_ready, frame_len, fifo_empty, read_data, tx_ready,
    output read_enable, read_start, read_error, tx_valid, tx_data, tx_err, busy
  );

  modport slave (
    output frame_ready, frame_len, fifo_empty, read_data, tx_ready,
    input  read_enable, read_start, read_error, tx_valid, tx_data, tx_err, busy
  );
endinterface

// File: rtl/eth_tx_framer.sv
// Ethernet TX framer: preamble, SFD, FIFO payload, CRC-32 FCS, IFG. One output register;
// a byte is loaded whenever the slot is free (!tx_valid | tx_ready), so MAC stalls hold the pipe.
module eth_tx_framer #(
  parameter int unsigned PREAMBLE_LEN   = 7,
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned UNDERRUN_LIMIT = 255
) (
  input logic             clk,
  input logic             n_rst,
  eth_tx_framer_if.master bus
);

  localparam int PW = (PREAMBLE_LEN   > 1) ? $clog2(PREAMBLE_LEN)   : 1;
  localparam int IW = (IFG_CYCLES     > 1) ? $clog2(IFG_CYCLES)     : 1;
  localparam int UW = (UNDERRUN_LIMIT > 1) ? $clog2(UNDERRUN_LIMIT) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_CYCLES - 1);
  localparam logic [UW-1:0] UR_LAST  = UW'(UNDERRUN_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_FCS, S_IFG
  } state_t;

  state_t        state, state_n;
  logic [8:0]    remaining;
  logic [PW-1:0] pre_cnt;
  logic [1:0]    fcs_idx;
  logic [IW-1:0] ifg_cnt;
  logic [UW-1:0] ur_cnt;
  logic [31:0]   crc;
  logic [31:0]   fcs_word;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;

  logic          slot_free;
  logic          start;
  logic          pop;
  logic          starve;
  logic          abort;
  logic          ifg_tick;
  logic          load_en;
  logic [7:0]    load_dat;

  // Reflected CRC-32, one input bit per iteration, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign slot_free = !tx_valid_q || bus.tx_ready;
  assign start     = (state == S_IDLE) && bus.frame_ready && (bus.frame_len != 9'd0);
  assign pop       = (state == S_PAYLOAD) && slot_free && !bus.fifo_empty;
  assign starve    = (state == S_PAYLOAD) && slot_free && bus.fifo_empty;
  assign abort     = starve && (ur_cnt == UR_LAST);
  // IFG time only runs once the final byte has left the output register.
  assign ifg_tick  = (state == S_IFG) && !tx_valid_q;
  assign fcs_word  = ~crc;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start) state_n = S_PREAMBLE;
      S_PREAMBLE: if (slot_free && (pre_cnt == PRE_LAST)) state_n = S_SFD;
      S_SFD:      if (slot_free) state_n = S_PAYLOAD;
      S_PAYLOAD: begin
        if (pop && (remaining == 9'd1)) state_n = S_FCS;
        else if (abort)                 state_n = S_IFG;
      end
      S_FCS:      if (slot_free && (fcs_idx == 2'd3)) state_n = S_IFG;
      S_IFG:      if (ifg_tick && (ifg_cnt == IFG_LAST)) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.read_enable = pop;
    bus.read_start  = 1'b0;
    bus.read_error  = abort;
    bus.tx_err      = abort;
    bus.busy        = (state != S_IDLE);
    load_en         = 1'b0;
    load_dat        = 8'h00;
    case (state)
      S_PREAMBLE: begin
        load_en  = slot_free;
        load_dat = 8'h55;
      end
      S_SFD: begin
        load_en        = slot_free;
        load_dat       = 8'hD5;
        bus.read_start = slot_free;
      end
      S_PAYLOAD: begin
        load_en  = pop;
        load_dat = bus.read_data;
      end
      S_FCS: begin
        load_en  = slot_free;
        load_dat = fcs_word[{fcs_idx, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Output register: reload when free, otherwise drain once the MAC takes the byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else if (load_en) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= load_dat;
    end else if (slot_free) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;

  // Frame counters and running CRC
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      remaining <= 9'd0;
      pre_cnt   <= '0;
      fcs_idx   <= 2'd0;
      ifg_cnt   <= '0;
      ur_cnt    <= '0;
      crc       <= 32'hFFFF_FFFF;
    end else begin
      if (start) begin
        remaining <= bus.frame_len;
        pre_cnt   <= '0;
        fcs_idx   <= 2'd0;
        ifg_cnt   <= '0;
        ur_cnt    <= '0;
        crc       <= 32'hFFFF_FFFF;
      end
      if ((state == S_PREAMBLE) && slot_free) pre_cnt <= pre_cnt + 1'b1;
      if (pop) begin
        remaining <= remaining - 9'd1;
        crc       <= crc_byte(crc, bus.read_data);
        ur_cnt    <= '0;
      end else if (starve && !abort) begin
        ur_cnt <= ur_cnt + 1'b1;
      end
      if ((state == S_FCS) && slot_free) fcs_idx <= fcs_idx + 2'd1;
      if (ifg_tick) ifg_cnt <= ifg_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: FIFO/MAC model, table-driven frames plus underrun, reset and ignore cases.
module tb_eth_tx_framer;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  eth_tx_framer_if bus();

  eth_tx_framer #(.PREAMBLE_LEN(7), .IFG_CYCLES(12), .UNDERRUN_LIMIT(255)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  typedef struct {
    int          len;
    logic [71:0] pl;    // byte i at pl[8*i +: 8]
    int          mode;  // 0 ready, 1 toggle, 2 ready 1/3, 3 fifo bubbles, 4 stray frame_ready, 5 starve
    logic [31:0] fcs;
  } vec_t;

  vec_t       vecs[6];
  vec_t       va;
  logic [7:0] q[$];
  logic [7:0] got[$];
  logic [7:0] expq[$];
  int n_pass = 0, n_total = 0;
  int n_re, n_rs, n_err, n_txerr, bad_re, bad_hold;
  int last_acc, idle_at, re3_at, err_at, txerr_at, v_after;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic build_exp(input vec_t v);
    expq.delete();
    for (int i = 0; i < 7; i++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    for (int i = 0; i < v.len; i++) expq.push_back(v.pl[8*i +: 8]);
    for (int i = 0; i < 4; i++) expq.push_back(v.fcs[8*i +: 8]);
  endtask

  task automatic run_frame(input vec_t v);
    bit         seen_busy = 0;
    bit         prev_stall = 0;
    bit         re_s;
    logic [7:0] prev_dat = 8'h00;
    int         nq;
    q.delete(); got.delete();
    n_re = 0; n_rs = 0; n_err = 0; n_txerr = 0; bad_re = 0; bad_hold = 0;
    last_acc = -1; idle_at = -1; re3_at = -1; err_at = -1; txerr_at = -1; v_after = -1;
    nq = (v.mode == 5) ? 3 : v.len;
    for (int i = 0; i < nq; i++) q.push_back(v.pl[8*i +: 8]);
    bus.frame_ready = 1'b1;
    bus.frame_len   = 9'(v.len);
    for (int c = 0; c < 3000 && idle_at < 0; c++) begin
      if (c == 1) bus.frame_ready = 1'b0;
      if (v.mode == 4 && c == 20) begin bus.frame_ready = 1'b1; bus.frame_len = 9'd5; end
      if (v.mode == 4 && c == 21) bus.frame_ready = 1'b0;
      case (v.mode)
        1:       bus.tx_ready = (c % 2 == 0);
        2:       bus.tx_ready = (c % 3 == 0);
        default: bus.tx_ready = 1'b1;
      endcase
      bus.fifo_empty = (q.size() == 0) || (v.mode == 3 && c % 4 == 1);
      bus.read_data  = (q.size() != 0) ? q[0] : 8'h00;
      @(negedge clk);
      if (prev_stall && !(bus.tx_valid && bus.tx_data == prev_dat)) bad_hold++;
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_dat   = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin got.push_back(bus.tx_data); last_acc = c; end
      re_s = bus.read_enable;
      if (re_s) begin
        n_re++;
        if (bus.fifo_empty) bad_re++;
        if (n_re == 3) re3_at = c;
      end
      if (err_at >= 0 && c == err_at + 1) v_after = int'(bus.tx_valid);
      if (bus.read_error) begin n_err++; err_at = c; end
      if (bus.tx_err) begin n_txerr++; txerr_at = c; end
      if (bus.read_start) n_rs++;
      if (bus.busy) seen_busy = 1;
      else if (seen_busy) idle_at = c;
      @(posedge clk); #1;
      if (re_s && q.size() != 0) void'(q.pop_front());
    end
    chk("frame_done", int'(idle_at >= 0), 1);
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    build_exp(v);
    chk({tag, "_nbytes"}, got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hDEAD, {24'h0, expq[i]});
    chk({tag, "_reads"}, n_re, v.len);
    chk({tag, "_read_start"}, n_rs, 1);
    chk({tag, "_read_error"}, n_err, 0);
    chk({tag, "_tx_err"}, n_txerr, 0);
    chk({tag, "_re_when_empty"}, bad_re, 0);
    chk({tag, "_stall_hold"}, bad_hold, 0);
    chk({tag, "_ifg"}, idle_at - last_acc - 1, 12);
  endtask

  initial begin
    int nre, rs, errs;
    bit re_s;
    bus.frame_ready = 1'b0; bus.frame_len = 9'd0; bus.fifo_empty = 1'b1;
    bus.read_data = 8'h00; bus.tx_ready = 1'b1;

    vecs[0] = '{9, 72'h393837363534333231, 0, 32'hCBF43926};
    vecs[1] = '{9, 72'h393837363534333231, 1, 32'hCBF43926};
    vecs[2] = '{1, 72'h0,                  0, 32'hD202EF8D};
    vecs[3] = '{3, 72'h636261,             2, 32'h352441C2};
    vecs[4] = '{9, 72'h393837363534333231, 3, 32'hCBF43926};
    vecs[5] = '{9, 72'h393837363534333231, 4, 32'hCBF43926};
    va      = '{1, 72'h61,                 0, 32'hE8B7BE43};

    // Reset values
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_read_enable", bus.read_enable, 0);
    chk("rst_flags", {bus.read_start, bus.read_error, bus.tx_err}, 0);
    @(posedge clk); #1 n_rst = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      run_frame(vecs[k]);
      check_frame($sformatf("vec%0d", k), vecs[k]);
    end

    // Underrun: only 3 of 9 bytes ever arrive
    va.mode = 5;
    run_frame('{9, 72'h393837363534333231, 5, 32'h0});
    chk("ur_reads", n_re, 3);
    chk("ur_read_error_cnt", n_err, 1);
    chk("ur_tx_err_cnt", n_txerr, 1);
    chk("ur_delay", err_at - re3_at, 255);
    chk("ur_err_align", txerr_at, err_at);
    chk("ur_nbytes", got.size(), 11);
    chk("ur_last_byte", (got.size() == 11) ? {24'h0, got[10]} : 32'hDEAD, 8'h33);
    chk("ur_valid_after", v_after, 0);
    chk("ur_ifg", idle_at - err_at, 13);
    va.mode = 0;

    // Reset mid-payload
    q.delete(); nre = 0; rs = 0; errs = 0;
    for (int i = 0; i < 9; i++) q.push_back(vecs[0].pl[8*i +: 8]);
    bus.frame_ready = 1'b1; bus.frame_len = 9'd9; bus.tx_ready = 1'b1;
    for (int c = 0; c < 100 && nre < 2; c++) begin
      if (c == 1) bus.frame_ready = 1'b0;
      bus.fifo_empty = (q.size() == 0);
      bus.read_data  = (q.size() != 0) ? q[0] : 8'h00;
      @(negedge clk);
      re_s = bus.read_enable;
      if (re_s) nre++;
      rs += int'(bus.read_start);
      errs += int'(bus.read_error);
      @(posedge clk); #1;
      if (re_s && q.size() != 0) void'(q.pop_front());
    end
    bus.frame_ready = 1'b0;
    chk("mid_reads", nre, 2);
    bus.fifo_empty = 1'b0; bus.read_data = q[0];
    #1 n_rst = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_tx_data", bus.tx_data, 8'h00);
    chk("mid_rst_read_enable", bus.read_enable, 0);
    chk("mid_rst_flags", {bus.read_start, bus.read_error, bus.tx_err}, 0);
    q.delete(); bus.fifo_empty = 1'b1;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      errs += int'(bus.read_error);
      rs += int'(bus.busy);
    end
    chk("mid_rst_no_error", errs, 0);
    chk("mid_rst_idle_after", rs, 1);  // only the single SFD pulse before reset
    @(posedge clk); #1;
    run_frame(va);
    check_frame("post_rst", va);

    // frame_len == 0 is ignored
    bus.frame_ready = 1'b1; bus.frame_len = 9'd0;
    rs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      rs += int'(bus.busy) + int'(bus.read_start);
      @(posedge clk); #1;
      bus.frame_ready = 1'b0;
    end
    chk("len0_ignored", rs, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
